// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, opcode constants, instruction payload and FSM
// state encoding for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W   = 8;
  localparam int unsigned OPCODE_W  = 4;
  localparam int unsigned OPERAND_W = 4;

  localparam logic [OPCODE_W-1:0] OP_JMP = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'b1001;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

  // One program word: opcode in the upper nibble, operand in the lower.
  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] operand;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALTED
  } state_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction handshake between the fetch stage and the control unit.
//   instr_valid  fetch -> control  opcode/operand valid
//   instr_ready  control -> fetch  instruction accepted
//   opcode       fetch -> control  current opcode
//   operand      fetch -> control  current operand
//   zero_flag    control -> fetch  ALU zero flag, sampled on a JZ handshake
// master = fetch side, slave = control unit side.
interface fetch_if;
  import fetch_pkg::*;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [OPCODE_W-1:0]  opcode;
  logic [OPERAND_W-1:0] operand;
  logic                 zero_flag;

  modport master (
    output instr_valid, opcode, operand,
    input  instr_ready, zero_flag
  );

  modport slave (
    input  instr_valid, opcode, operand,
    output instr_ready, zero_flag
  );
endinterface

// File: rtl/fetch_rom.sv
// fetch_rom: DEPTH x INSTR_W writable program store.
//   clk        write clock
//   we         write enable (already qualified by the caller)
//   waddr      write address
//   wdata      write data
//   raddr      read address
//   rd_data_c  combinational read data
// Contents are never reset.
module fetch_rom
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  instr_t             wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output instr_t             rd_data_c
);

  instr_t mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read port; registered by the fetch FSM.
  assign rd_data_c = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the control unit.
// Holds the program store and PC, issues opcode/operand over a valid/ready
// handshake and resolves JMP, JZ and HLT locally.
//   clk, rst        clock, synchronous active-high reset
//   start           run from address 0 (IDLE/HALTED only)
//   prog_we/addr/data  program store write port (IDLE/HALTED only)
//   bus             fetch_if master: instr_valid/ready, opcode, operand, zero_flag
//   pc              address of the current instruction
//   busy            high in FETCH or ISSUE
//   halted          high in HALTED
// Optional build macro FETCH_PERF_EN adds perf_cycles and perf_issued
// (saturating 16-bit busy-cycle and handshake counters).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [INSTR_W-1:0]  prog_data,
  fetch_if.master             bus,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]         perf_cycles,
  output logic [15:0]         perf_issued
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jump_pc;
  instr_t            ir;
  instr_t            rd_instr_c;
  logic              ir_load;
  logic              stopped;
  logic              fire;

  // Start and program writes are only honoured when not executing.
  assign stopped = (state == IDLE) || (state == HALTED);
  assign fire    = (state == ISSUE) && bus.instr_ready;

  // DEPTH is a power of two, so the natural ADDR_W overflow is the wrap.
  assign pc_inc  = pc + ADDR_W'(1);
  assign jump_pc = ADDR_W'(ir.operand);

  fetch_rom #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk       (clk),
    .we        (prog_we && stopped),
    .waddr     (prog_addr),
    .wdata     (instr_t'(prog_data)),
    .raddr     (pc),
    .rd_data_c (rd_instr_c)
  );

  // Next-state and PC selection.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_load   = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nxt = FETCH;
          pc_nxt    = '0;
        end
      end
      FETCH: begin
        ir_load   = 1'b1;
        state_nxt = (rd_instr_c.opcode == OP_HLT) ? HALTED : ISSUE;
      end
      ISSUE: begin
        if (bus.instr_ready) begin
          state_nxt = FETCH;
          case (ir.opcode)
            OP_JMP:  pc_nxt = jump_pc;
            OP_JZ:   pc_nxt = bus.zero_flag ? jump_pc : pc_inc;
            default: pc_nxt = pc_inc;
          endcase
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, PC, instruction register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pc              <= '0;
      ir              <= '0;
      bus.instr_valid <= 1'b0;
      busy            <= 1'b0;
      halted          <= 1'b0;
    end else begin
      state           <= state_nxt;
      pc              <= pc_nxt;
      if (ir_load) begin
        ir <= rd_instr_c;
      end
      bus.instr_valid <= (state_nxt == ISSUE);
      busy            <= (state_nxt == FETCH) || (state_nxt == ISSUE);
      halted          <= (state_nxt == HALTED);
    end
  end

  assign bus.opcode  = ir.opcode;
  assign bus.operand = ir.operand;

`ifdef FETCH_PERF_EN
  // Saturating counters, cleared on reset or an accepted start.
  always_ff @(posedge clk) begin
    if (rst || (start && stopped)) begin
      perf_cycles <= '0;
      perf_issued <= '0;
    end else begin
      if (((state == FETCH) || (state == ISSUE)) && (perf_cycles != 16'hFFFF)) begin
        perf_cycles <= perf_cycles + 16'd1;
      end
      if (fire && (perf_issued != 16'hFFFF)) begin
        perf_issued <= perf_issued + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (DEPTH=16).
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [7:0]        prog_data;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
`ifdef FETCH_PERF_EN
  logic [15:0]       perf_cycles;
  logic [15:0]       perf_issued;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_if bus ();

  fetch_unit #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .bus       (bus),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_issued (perf_issued)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_issue(input string tag, input logic [3:0] op,
                             input logic [3:0] opnd, input logic [3:0] p);
    check({tag, "_valid"},   32'(bus.instr_valid), 32'd1);
    check({tag, "_opcode"},  32'(bus.opcode),      32'(op));
    check({tag, "_operand"}, 32'(bus.operand),     32'(opnd));
    check({tag, "_pc"},      32'(pc),              32'(p));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    bus.instr_ready = 1'b0; bus.zero_flag = 1'b0;
    tick(); tick();
    check("rst_valid",   32'(bus.instr_valid), 32'd0);
    check("rst_opcode",  32'(bus.opcode),      32'd0);
    check("rst_operand", 32'(bus.operand),     32'd0);
    check("rst_pc",      32'(pc),              32'd0);
    check("rst_busy",    32'(busy),            32'd0);
    check("rst_halted",  32'(halted),          32'd0);
    rst = 1'b0;

    // Basic issue, backpressure, then HLT.
    wr(4'd0, 8'h35);
    wr(4'd1, 8'hF0);
    go();
    check("fetch_busy",  32'(busy),            32'd1);
    check("fetch_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    check_issue("issue0", 4'h3, 4'h5, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_issue("bp", 4'h3, 4'h5, 4'd0);
    end
    bus.instr_ready = 1'b1;
    tick();
    check("hs_pc",    32'(pc),              32'd1);
    check("hs_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    check("hlt_halted", 32'(halted),            32'd1);
    check("hlt_valid",  32'(bus.instr_valid),   32'd0);
    check("hlt_busy",   32'(busy),              32'd0);
    tick();
    check("hlt_hold_halted", 32'(halted),          32'd1);
    check("hlt_hold_valid",  32'(bus.instr_valid), 32'd0);

    // JZ taken, JMP.
    bus.instr_ready = 1'b0;
    wr(4'd0,  8'h9A);
    wr(4'd10, 8'h83);
    wr(4'd3,  8'hF0);
    go(); tick();
    check_issue("jz1", 4'h9, 4'hA, 4'd0);
    bus.zero_flag = 1'b1; bus.instr_ready = 1'b1;
    tick();
    bus.zero_flag = 1'b0; bus.instr_ready = 1'b0;
    check("jz_taken_pc", 32'(pc), 32'd10);
    tick();
    check_issue("jmp", 4'h8, 4'h3, 4'd10);
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;
    check("jmp_pc", 32'(pc), 32'd3);
    tick();
    check("jmp_hlt_halted", 32'(halted), 32'd1);

    // JZ not taken.
    go(); tick();
    check_issue("jz0", 4'h9, 4'hA, 4'd0);
    bus.zero_flag = 1'b0; bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("jz_nt_pc", 32'(pc), 32'd1);
    tick();
    check("jz_nt_halted", 32'(halted), 32'd1);

    // PC wrap 15 -> 0.
    wr(4'd0,  8'h8F);
    wr(4'd15, 8'h11);
    go(); tick();
    check_issue("wr_jmp", 4'h8, 4'hF, 4'd0);
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;
    check("to15_pc", 32'(pc), 32'd15);
    tick();
    check_issue("at15", 4'h1, 4'h1, 4'd15);
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;
    check("wrap_pc", 32'(pc), 32'd0);
    tick();
    check_issue("after_wrap", 4'h8, 4'hF, 4'd0);

    // Write lockout and start ignored while busy.
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'hF0;
    tick();
    prog_we = 1'b0;
    check_issue("lockout_hold", 4'h8, 4'hF, 4'd0);
    go();
    check_issue("busy_start", 4'h8, 4'hF, 4'd0);

    // Reset mid-ISSUE; program survives.
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_valid",  32'(bus.instr_valid), 32'd0);
    check("midrst_busy",   32'(busy),            32'd0);
    check("midrst_halted", 32'(halted),          32'd0);
    check("midrst_pc",     32'(pc),              32'd0);
    tick();
    check("idle_valid", 32'(bus.instr_valid), 32'd0);
    go(); tick();
    check_issue("rerun", 4'h8, 4'hF, 4'd0);
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;
    tick();
    check_issue("rerun15", 4'h1, 4'h1, 4'd15);

    // Write and start in the same cycle: FETCH sees the new word.
    rst = 1'b1; tick(); rst = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h47; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    tick();
    check_issue("wr_start", 4'h4, 4'h7, 4'd0);

    // Three instructions then HLT at full throughput.
    rst = 1'b1; tick(); rst = 1'b0;
    wr(4'd0, 8'h10);
    wr(4'd1, 8'h20);
    wr(4'd2, 8'h30);
    wr(4'd3, 8'hF0);
    bus.instr_ready = 1'b1;
    go();
    for (int i = 0; i < 6; i++) tick();
    check("run3_not_halted", 32'(halted), 32'd0);
    tick();
    check("run3_halted", 32'(halted),            32'd1);
    check("run3_valid",  32'(bus.instr_valid),   32'd0);
    check("run3_pc",     32'(pc),                32'd3);
`ifdef FETCH_PERF_EN
    check("perf_issued", 32'(perf_issued), 32'd3);
    check("perf_cycles", 32'(perf_cycles), 32'd7);
    tick(); tick();
    check("perf_issued_hold", 32'(perf_issued), 32'd3);
    check("perf_cycles_hold", 32'(perf_cycles), 32'd7);
    go();
    check("perf_clr_issued", 32'(perf_issued), 32'd0);
    check("perf_clr_cycles", 32'(perf_cycles), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the processor's control unit and replaces its fixed opcode.
- Holds a small writable program store and a program counter (PC).
- Splits each 8-bit instruction into a 4-bit opcode and a 4-bit operand.
- Presents opcode/operand to the control unit through a valid/ready handshake.
- Resolves JMP, JZ (using the ALU zero flag) and HLT itself.

Parameters:
- DEPTH, 16, number of program words; power of two, range 2..256.
- ADDR_W, $clog2(DEPTH), width of the PC and the program address.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution at address 0; honoured only in IDLE or HALTED.
- prog_we  in  1  program store write enable; honoured only in IDLE or HALTED.
- prog_addr  in  ADDR_W  program store write address.
- prog_data  in  8  instruction word: [7:4] opcode, [3:0] operand.
- zero_flag  in  1  ALU result-is-zero, sampled on the JZ handshake.
- instr_ready  in  1  control unit accepts the current instruction.
- instr_valid  out  1  opcode/operand valid.
- opcode  out  4  current instruction opcode.
- operand  out  4  current instruction operand (address/immediate).
- pc  out  ADDR_W  address of the current instruction.
- busy  out  1  high in FETCH or ISSUE.
- halted  out  1  high in HALTED.

Behaviour:
- Reset values: state=IDLE, pc=0, instr_valid=0, opcode=0, operand=0, busy=0, halted=0. The program store is not reset; its contents survive rst.
- FSM states:
  - IDLE: waits for start; start -> FETCH with pc=0.
  - FETCH: one cycle; the instruction register loads mem[pc]. HLT -> HALTED; any other opcode -> ISSUE.
  - ISSUE: instr_valid=1; opcode/operand stay stable until the handshake (instr_valid & instr_ready); then -> FETCH with pc updated.
  - HALTED: halted=1, instr_valid=0; start -> FETCH with pc=0.
- PC update at the handshake:
  - JMP (4'b1000): pc = operand (zero-extended, or truncated to ADDR_W).
  - JZ (4'b1001): pc = operand if zero_flag=1, else pc+1.
  - All other opcodes: pc+1.
  - pc+1 wraps from DEPTH-1 to 0.
- JMP and JZ are issued to the control unit (it treats them as NOPs). HLT is never issued.
- Latency: start sampled at cycle N -> FETCH at N+1 -> instr_valid at N+2. With instr_ready held high, throughput is one instruction every 2 cycles.
- instr_ready low: stay in ISSUE indefinitely; outputs held; no PC change.
- Program store writes:
  - Synchronous write; the read is combinational and registered in FETCH.
  - prog_we in FETCH or ISSUE is ignored.
  - prog_we and start in the same cycle: the write completes, and the following FETCH reads the new data if the addresses match.
- start while busy: ignored.
- rst mid-operation: pending instruction dropped, instr_valid=0 the next cycle, returns to IDLE.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_cycles[15:0] and perf_issued[15:0].
  - perf_cycles counts cycles with busy=1.
  - perf_issued counts handshakes.
  - Both saturate at 16'hFFFF and clear on rst or on an accepted start.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fetch_pkg: INSTR_W=8, OPCODE_W=4, OPERAND_W=4; opcode constants OP_JMP=4'b1000, OP_JZ=4'b1001, OP_HLT=4'b1111; state enum {IDLE, FETCH, ISSUE, HALTED}.
- One sub-module, fetch_rom: DEPTH x 8 array, synchronous write port, combinational read port.
- FSM, PC and perf counters live in fetch_unit.

Test Plan:
- Reset/idle: after rst, write mem[0]=8'h35, mem[1]=8'hF0, then pulse start -> instr_valid rises 2 cycles later with opcode=3, operand=5, pc=0; next instruction is HLT -> halted=1, instr_valid never asserted for it.
- Backpressure: hold instr_ready=0 for 5 cycles during ISSUE -> opcode, operand and pc stay stable, instr_valid stays 1; release -> pc advances to 1.
- Branches: mem[0]=8'h9A (JZ 10). Handshake with zero_flag=1 -> next pc=10. Repeat with zero_flag=0 -> next pc=1. mem[10]=8'h83 (JMP 3) -> next pc=3.
- Wrap: DEPTH=16, mem[15]=8'h11, mem[0..14] all NOP-class opcodes, run from 15 -> pc wraps to 0.
- Write lockout and reset: prog_we during ISSUE leaves memory unchanged. Assert rst in ISSUE -> instr_valid=0 the next cycle, state IDLE, program preserved; start reruns it identically.
- FETCH_PERF_EN: 3 instructions followed by HLT with instr_ready=1 -> perf_issued=3, perf_cycles=7.
